// File: rtl/trap_ctrl_if.sv
// Bundle between the MEM stage / interrupt lines and the CSR file as seen by trap_ctrl.
// slave is the trap_ctrl side; master drives the pipeline and CSR-side inputs.
interface trap_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [5:0]  mem_exc;
  logic        mem_ecall;
  logic        mem_mret;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_soft;
  logic        csr_branch_signal;
  logic [31:0] trap_pc;
  logic [5:0]  trap_id;
  logic        trap_ecall;
  logic        trap_mret;
  logic        commit_kill;
  logic        flush;
  logic [31:0] irq_pending;
  logic        busy;
  logic        redirect_err;

  modport slave (
    input  mem_valid, mem_pc, mem_exc, mem_ecall, mem_mret, mem_read, mem_write,
           mem_size, mem_addr, mstatus_mie, mie, irq_ext, irq_timer, irq_soft,
           csr_branch_signal,
    output trap_pc, trap_id, trap_ecall, trap_mret, commit_kill, flush,
           irq_pending, busy, redirect_err
  );

  modport master (
    output mem_valid, mem_pc, mem_exc, mem_ecall, mem_mret, mem_read, mem_write,
           mem_size, mem_addr, mstatus_mie, mie, irq_ext, irq_timer, irq_soft,
           csr_branch_signal,
    input  trap_pc, trap_id, trap_ecall, trap_mret, commit_kill, flush,
           irq_pending, busy, redirect_err
  );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-point trap arbiter: merges pipeline exceptions, MEM-stage misalignment and
// synchronised machine interrupts into one trap/ecall/mret event for the CSR file.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WAIT_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   redirect_err_q, redirect_err_d;
  logic [31:0]            trap_pc_q, trap_pc_d;
  logic [5:0]             trap_id_q, trap_id_d;
  logic                   trap_ecall_q, trap_ecall_d;
  logic                   trap_mret_q, trap_mret_d;
  logic                   commit_kill_s;
  logic                   misaligned_s;
  logic                   ext_hit_s, timer_hit_s, soft_hit_s;
  logic [SYNC_STAGES-1:0] ext_sync_q, timer_sync_q, soft_sync_q;

  // Interrupt-line synchronisers; only the last stage is ever observed
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync_q   <= '0;
      timer_sync_q <= '0;
      soft_sync_q  <= '0;
    end else begin
      ext_sync_q   <= {ext_sync_q[SYNC_STAGES-2:0], bus.irq_ext};
      timer_sync_q <= {timer_sync_q[SYNC_STAGES-2:0], bus.irq_timer};
      soft_sync_q  <= {soft_sync_q[SYNC_STAGES-2:0], bus.irq_soft};
    end
  end

  assign ext_hit_s   = bus.mstatus_mie & ext_sync_q[SYNC_STAGES-1]   & bus.mie[11];
  assign timer_hit_s = bus.mstatus_mie & timer_sync_q[SYNC_STAGES-1] & bus.mie[7];
  assign soft_hit_s  = bus.mstatus_mie & soft_sync_q[SYNC_STAGES-1]  & bus.mie[3];

  // Data-address alignment check; size 11 is handled like a word access
  always_comb begin
    misaligned_s = 1'b0;
    case (bus.mem_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = bus.mem_addr[0];
      default: misaligned_s = (bus.mem_addr[1:0] != 2'b00);
    endcase
  end

  // Event selection, next-state and WAIT timeout bookkeeping
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    redirect_err_d = redirect_err_q;
    trap_pc_d      = 32'h0000_0000;
    trap_id_d      = 6'd0;
    trap_ecall_d   = 1'b0;
    trap_mret_d    = 1'b0;
    commit_kill_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          if (ext_hit_s | soft_hit_s | timer_hit_s) begin
            state_d       = S_ISSUE;
            commit_kill_s = 1'b1;
            trap_pc_d     = bus.mem_pc;
            if (ext_hit_s) begin
              trap_id_d = 6'h2B;
            end else if (soft_hit_s) begin
              trap_id_d = 6'h23;
            end else begin
              trap_id_d = 6'h27;
            end
          end else if (bus.mem_exc != 6'd0) begin
            state_d       = S_ISSUE;
            commit_kill_s = 1'b1;
            trap_pc_d     = bus.mem_pc;
            trap_id_d     = bus.mem_exc;
          end else if (bus.mem_ecall) begin
            state_d       = S_ISSUE;
            commit_kill_s = 1'b1;
            trap_pc_d     = bus.mem_pc;
            trap_ecall_d  = 1'b1;
          end else if (misaligned_s & (bus.mem_read | bus.mem_write)) begin
            state_d       = S_ISSUE;
            commit_kill_s = 1'b1;
            trap_pc_d     = bus.mem_pc;
            trap_id_d     = bus.mem_write ? 6'd6 : 6'd4;
          end else if (bus.mem_mret) begin
            state_d     = S_ISSUE;
            trap_pc_d   = bus.mem_pc;
            trap_mret_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (bus.csr_branch_signal) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_IDLE;
          redirect_err_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered trap outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      redirect_err_q <= 1'b0;
      trap_pc_q      <= 32'h0000_0000;
      trap_id_q      <= 6'd0;
      trap_ecall_q   <= 1'b0;
      trap_mret_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_err_q <= redirect_err_d;
      trap_pc_q      <= trap_pc_d;
      trap_id_q      <= trap_id_d;
      trap_ecall_q   <= trap_ecall_d;
      trap_mret_q    <= trap_mret_d;
    end
  end

  assign bus.trap_pc      = trap_pc_q;
  assign bus.trap_id      = trap_id_q;
  assign bus.trap_ecall   = trap_ecall_q;
  assign bus.trap_mret    = trap_mret_q;
  assign bus.commit_kill  = commit_kill_s;
  assign bus.flush        = (state_q != S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.redirect_err = redirect_err_q;
  assign bus.irq_pending  = {20'h0_0000, ext_sync_q[SYNC_STAGES-1], 3'b000,
                             timer_sync_q[SYNC_STAGES-1], 3'b000,
                             soft_sync_q[SYNC_STAGES-1], 3'b000};
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a cycle-level protocol model predicts events,
// a monitor pops them when the DUT presents trap outputs.
module tb_trap_ctrl;
  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();
  trap_ctrl #(.SYNC_STAGES(SYNC), .WAIT_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [5:0]  id;
    logic        ec;
    logic        mr;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // stimulus state
  bit          r, v, rd, wr, ec, mr, mmie;
  logic [5:0]  exc;
  logic [1:0]  sz;
  logic [31:0] pc, addr, mie_v;
  bit   [2:0]  irq;             // {ext, timer, soft}
  int          force_w = -1;

  // protocol model state
  bit [2:0] hist[$];
  int busy_from = 0, idle_at = 0, redir_at = -1, err_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit misal(logic [1:0] s, logic [31:0] a);
    int bytes;
    bytes = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    return (a % bytes) != 0;
  endfunction

  task automatic clr();
    v = 0; rd = 0; wr = 0; ec = 0; mr = 0; exc = 6'd0; sz = 2'd0;
    pc = 32'h0; addr = 32'h0;
  endtask

  task automatic step();
    bit [2:0]    pend;
    bit          busy_n, ev, kill, e_ec, e_mr;
    logic [5:0]  id;
    int          w;
    @(posedge clk); #1;
    busy_n = (cyc >= busy_from) && (cyc < idle_at);
    rst = r;
    bus.mem_valid = v & ~r;   bus.mem_pc = pc;       bus.mem_exc = exc;
    bus.mem_ecall = ec;       bus.mem_mret = mr;     bus.mem_read = rd;
    bus.mem_write = wr;       bus.mem_size = sz;     bus.mem_addr = addr;
    bus.mstatus_mie = mmie;   bus.mie = mie_v;
    bus.irq_ext = irq[2];     bus.irq_timer = irq[1]; bus.irq_soft = irq[0];
    bus.csr_branch_signal = (cyc == redir_at) ||
        ((!busy_n || cyc == busy_from) && $urandom_range(0, 7) == 0);
    pend = hist[0];
    ev = 0; kill = 0; e_ec = 0; e_mr = 0; id = 6'd0;
    if (!r && v && !busy_n) begin
      if (mmie && ((pend[2] && mie_v[11]) || (pend[0] && mie_v[3]) || (pend[1] && mie_v[7]))) begin
        ev = 1; kill = 1;
        id = (pend[2] && mie_v[11]) ? 6'd43 : ((pend[0] && mie_v[3]) ? 6'd35 : 6'd39);
      end else if (exc != 6'd0) begin
        ev = 1; kill = 1; id = exc;
      end else if (ec) begin
        ev = 1; kill = 1; e_ec = 1;
      end else if ((rd || wr) && misal(sz, addr)) begin
        ev = 1; kill = 1; id = wr ? 6'd6 : 6'd4;
      end else if (mr) begin
        ev = 1; e_mr = 1;
      end
    end
    if (ev) begin
      sbq.push_back('{cyc + 1, pc, id, e_ec, e_mr});
      w = (force_w >= 0) ? force_w : $urandom_range(0, TMO + 2);
      busy_from = cyc + 1;
      if (w < TMO) begin
        redir_at = cyc + 2 + w;
        idle_at  = cyc + 3 + w;
      end else begin
        redir_at = -1;
        idle_at  = cyc + 2 + TMO;
        if (err_at < 0) err_at = idle_at;
      end
    end
    @(negedge clk);
    chk("commit_kill", 32'(bus.commit_kill), 32'(kill));
    chk("busy", 32'(bus.busy), 32'(busy_n));
    chk("flush", 32'(bus.flush), 32'(busy_n));
    chk("redirect_err", 32'(bus.redirect_err), 32'(err_at >= 0 && cyc >= err_at));
    chk("irq_pending", bus.irq_pending,
        {20'h0, pend[2], 3'b000, pend[1], 3'b000, pend[0], 3'b000});
    hist.push_back(irq);
    void'(hist.pop_front());
    if (r) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
      busy_from = cyc + 1; idle_at = cyc + 1; redir_at = -1; err_at = -1;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: consumes the expected event due in this cycle, flags anything else
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mon_e = sbq.pop_front();
      chk("ev_pc", bus.trap_pc, mon_e.pc);
      chk("ev_id", 32'(bus.trap_id), 32'(mon_e.id));
      chk("ev_ecall", 32'(bus.trap_ecall), 32'(mon_e.ec));
      chk("ev_mret", 32'(bus.trap_mret), 32'(mon_e.mr));
    end else if (bus.trap_id != 6'd0 || bus.trap_ecall || bus.trap_mret) begin
      chk("unexpected_event", 32'd1, 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
    clr(); irq = 3'b000; mmie = 0; mie_v = 32'h0;
    r = 1; run(3); r = 0;
    chk("rst_trap_pc", bus.trap_pc, 32'h0);
    chk("rst_trap_id", 32'(bus.trap_id), 32'd0);
    run(2);

    // load misaligned word
    force_w = 3;
    v = 1; rd = 1; sz = 2'b10; addr = 32'h1002; pc = 32'h80; step();
    clr(); run(8);

    // exception beats ecall and store misalignment
    v = 1; exc = 6'd2; ec = 1; wr = 1; sz = 2'b10; addr = 32'h1001; pc = 32'h100; step();
    clr(); run(8);

    // ext and timer both raised, ext wins
    irq = 3'b110; mie_v = 32'h880; mmie = 1; run(SYNC + 1);
    v = 1; pc = 32'h200; force_w = 2; step();
    clr(); run(6);
    mmie = 0; v = 1; pc = 32'h204; run(3);
    clr(); irq = 3'b000; run(3);

    // mret does not kill the commit
    v = 1; mr = 1; pc = 32'h300; force_w = 4; step();
    clr(); run(8);

    // missing redirect times out
    force_w = 20;
    v = 1; ec = 1; pc = 32'h400; step();
    clr(); run(TMO + 4);

    // reset while waiting
    force_w = 9;
    v = 1; exc = 6'd1; pc = 32'h500; step();
    clr(); run(4);
    r = 1; step(); r = 0;
    run(4);

    // randomized traffic
    force_w = -1;
    for (int i = 0; i < 2000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      pc   = $urandom & 32'hFFFF_FFFC;
      addr = $urandom;
      sz   = 2'($urandom_range(0, 3));
      rd   = ($urandom_range(0, 1) == 1);
      wr   = ($urandom_range(0, 2) == 0);
      ec   = ($urandom_range(0, 7) == 0);
      mr   = ($urandom_range(0, 7) == 0);
      exc  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if ($urandom_range(0, 15) == 0) irq = irq ^ 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) mie_v = $urandom;
      if ($urandom_range(0, 31) == 0) mmie = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 299) == 0);
      step();
    end
    r = 0; clr(); irq = 3'b000; run(TMO + 6);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Commit-point trap arbiter that sits directly upstream of the CSR file.
- Watches the MEM-stage instruction and detects load/store misalignment itself.
- Merges exceptions carried down the pipeline with synchronised machine interrupts, then issues one trap/ecall/mret event per instruction to the CSR file.
- Holds the pipeline flushed until the CSR file's redirect (csr_branch_signal) arrives.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each interrupt-line synchroniser (min 2).
- WAIT_TIMEOUT, 8, cycles allowed in WAIT before a missing redirect is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- mem_valid  in  1  MEM-stage instruction valid
- mem_pc  in  32  PC of the MEM instruction
- mem_exc  in  6  exception code carried from IF/ID/EX; 0 = none, codes per csr_defs.v (all nonzero)
- mem_ecall  in  1  MEM instruction is ECALL
- mem_mret  in  1  MEM instruction is MRET
- mem_read  in  1  MEM instruction is a load
- mem_write  in  1  MEM instruction is a store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr  in  32  effective data address
- mstatus_mie  in  1  mstatus.MIE (csr_status[3])
- mie  in  32  mie CSR value
- irq_ext  in  1  async machine external interrupt
- irq_timer  in  1  async machine timer interrupt
- irq_soft  in  1  async machine software interrupt
- csr_branch_signal  in  1  CSR-file redirect strobe
- trap_pc  out  32  PC to CSR file (csr_trapPC)
- trap_id  out  6  trap code to CSR file (csr_trapID); bit5 = interrupt
- trap_ecall  out  1  ECALL pulse (csr_ecall)
- trap_mret  out  1  MRET pulse (csr_mret)
- commit_kill  out  1  combinational; suppress regfile/memory write of the MEM instruction
- flush  out  1  kill IF..EX and hold PC
- irq_pending  out  32  synchronised mip image: bit11 ext, bit7 timer, bit3 soft
- busy  out  1  state != IDLE
- redirect_err  out  1  sticky; redirect missed

Behaviour:
- Reset values (sync rst): state IDLE; all outputs 0; synchronisers cleared; redirect_err cleared.
- Synchronisers: each irq line passes through SYNC_STAGES flops; irq_pending reflects the last stage.
- Misalignment:
  - Half misaligned if addr[0]=1.
  - Word (or size 11) misaligned if addr[1:0]!=0.
  - Load gives code 4, store gives code 6; read+write together is treated as a store.
- Candidate event is evaluated only in IDLE with mem_valid=1. Priority, highest first:
  1. Interrupt: mstatus_mie=1 and (irq_pending & mie & 0x888)!=0. Within interrupts, ext(11) > soft(3) > timer(7). trap_id = {1'b1, cause[4:0]}.
  2. mem_exc!=0: trap_id = mem_exc.
  3. mem_ecall: trap_ecall=1, trap_id=0 (CSR file derives the code).
  4. Misalignment: trap_id = 4 or 6.
  5. mem_mret: trap_mret=1, trap_id=0.
- Any candidate in cycle T:
  - commit_kill=1 in T (all candidates except mret).
  - trap_pc=mem_pc registered, plus trap_id/trap_ecall/trap_mret, all valid exactly during T+1 only (state ISSUE).
- FSM:
  - IDLE -> ISSUE on candidate.
  - ISSUE -> WAIT unconditionally; trap outputs return to 0.
  - WAIT -> IDLE in the cycle csr_branch_signal=1.
  - WAIT -> IDLE after WAIT_TIMEOUT cycles without redirect; sets redirect_err.
- flush=1 in ISSUE and WAIT, including the cycle csr_branch_signal is seen.
- In ISSUE/WAIT, MEM inputs and interrupts are ignored; no second event is issued. Interrupts stay pending and are re-evaluated in IDLE.
- csr_branch_signal in IDLE or ISSUE is ignored.
- rst mid-ISSUE/WAIT: back to IDLE next edge; pulses and flush drop; no event reissued.
- Timeout counter: width clog2(WAIT_TIMEOUT+1); cleared on entry to WAIT; saturates, no wrap.

Test Plan:
- Load misaligned: mem_valid=1, mem_read=1, size=10, addr=0x1002, pc=0x80 -> commit_kill in T; T+1 trap_pc=0x80, trap_id=4; flush T+1..redirect; busy clears the cycle after csr_branch_signal.
- Priority: mem_exc=2 plus mem_ecall=1 plus store misaligned -> trap_id=2, trap_ecall=0; only one event issued.
- Interrupt: irq_timer and irq_ext both raised, mie=0x880, mstatus_mie=1 -> after SYNC_STAGES cycles and the next valid instruction at pc=0x200, trap_id=0x2B (ext wins), trap_pc=0x200. Repeat with mstatus_mie=0 -> no event.
- MRET: mem_mret=1, pc=0x300 -> commit_kill=0, trap_mret pulses one cycle in T+1, trap_id=0, flush until redirect.
- Timeout: trap issued, csr_branch_signal held 0 -> after 8 WAIT cycles FSM returns to IDLE, redirect_err=1 and stays 1 until rst.
- Reset mid-WAIT: assert rst during WAIT -> next cycle busy=0, flush=0, redirect_err=0, and no trap pulse follows.
